vram_write_arbiter: RTL

Shares the single write port of the 320x240x12-bit video RAM between several pixel producers (game logic, sprite blitter, text overlay) using round-robin arbitration with a valid/ready handshake. It also contains an optional hardware screen-clear engine that fills the whole framebuffer with one colour at one pixel per clock. It sits in the `write_clk` domain between the producers and the VGA driver's `write_addr`/`write_data`/`write_en` inputs.

---
 rtl/vram_write_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ==========================================================================
// vram_write_arbiter: round-robin arbiter for the VRAM write port, with an
// optional full-screen clear engine built when VRAM_ARB_CLEAR_EN is defined. Rev 1.0
// ==========================================================================
module vram_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 12,
  parameter int PIX_COUNT = 76800
) (
  input  logic                     write_clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clear_start,
  input  logic [DATA_W-1:0]        clear_color,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic                     oob_err,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  output logic                     write_en
);

  localparam int                IDX_W    = $clog2(NREQ);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [ADDR_W:0]   PIX_LIM  = (ADDR_W + 1)'(PIX_COUNT);

  logic [IDX_W-1:0]  last;
  logic [IDX_W:0]    cand;
  logic              found;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_in_range;
  logic              accept;

  logic              clear_block;
  logic              clear_wr;
  logic              clear_last;
  logic [ADDR_W-1:0] clear_addr;
  logic [DATA_W-1:0] clear_data;

  // Rotating search starting just after the most recent winner.
  always_comb begin
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NREQ)) begin
        cand = cand - (IDX_W + 1)'(NREQ);
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_addr     = req_addr[i*ADDR_W +: ADDR_W];
        win_data     = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = found && !clear_block;
      end
    end
  end

  assign accept       = |req_ready;
  assign win_in_range = ({1'b0, win_addr} < PIX_LIM);

`ifdef VRAM_ARB_CLEAR_EN
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(PIX_COUNT - 1);

  state_t            state;
  state_t            state_next;
  logic              clr_load;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] clr_color;

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start request in IDLE pre-empts the requesters in the same cycle.
  always_comb begin
    state_next  = state;
    clear_block = 1'b0;
    clear_wr    = 1'b0;
    clr_load    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          clear_block = 1'b1;
          clr_load    = 1'b1;
          state_next  = CLEAR;
        end
      end
      CLEAR: begin
        clear_block = 1'b1;
        clear_wr    = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt   <= '0;
      clr_color <= '0;
    end else if (clr_load) begin
      clr_cnt   <= '0;
      clr_color <= clear_color;
    end else if (clear_wr) begin
      clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
    end
  end

  assign clear_addr = clr_cnt;
  assign clear_data = clr_color;
  assign clear_last = (clr_cnt == CLR_LAST);
  assign clear_busy = (state == CLEAR);
`else
  logic unused_clear_inputs;

  assign unused_clear_inputs = ^{clear_start, clear_color};
  assign clear_block = 1'b0;
  assign clear_wr    = 1'b0;
  assign clear_last  = 1'b0;
  assign clear_addr  = '0;
  assign clear_data  = '0;
  assign clear_busy  = 1'b0;
`endif

  // Write port register; address/data hold whenever no write is issued.
  always_ff @(posedge write_clk or negedge reset_n) begin
    if (!reset_n) begin
      write_addr <= '0;
      write_data <= '0;
      write_en   <= 1'b0;
      clear_done <= 1'b0;
      oob_err    <= 1'b0;
      last       <= LAST_RST;
    end else begin
      write_en   <= 1'b0;
      clear_done <= 1'b0;
      if (clear_wr) begin
        write_addr <= clear_addr;
        write_data <= clear_data;
        write_en   <= 1'b1;
        clear_done <= clear_last;
      end else if (accept) begin
        last <= win_idx;
        if (win_in_range) begin
          write_addr <= win_addr;
          write_data <= win_data;
          write_en   <= 1'b1;
        end else begin
          oob_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
